par_reg_ctrl: RTL and testbench
===============================

// Module: par_reg_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the par_reg 512-bit parallel register. Shares the
//  register between NREQ requesters: round-robin grant, drives the WIDTH config,
//  assembles DATA_W-bit beats into the REG_W-bit image on op, then flags op_valid.
// PARAMETERS
//  NREQ   2    number of requesters (2..8)
//  DATA_W 32   beat width, divides REG_W
//  REG_W  512  register image width
//  WID_W  10   width-field bits, matches par_reg WIDTH
// PORTS
//  clock      in   1            single clock, rising edge
//  reset      in   1            synchronous, active-low
//  req        in   NREQ         per-requester request, held until op_valid/abort
//  req_width  in   NREQ*WID_W   requested width in bits, slice i = requester i
//  s_data     in   NREQ*DATA_W  beat data, slice i = requester i
//  s_valid    in   NREQ         beat valid
//  s_ready    out  NREQ         beat ready, only granted index can be high
//  gnt        out  NREQ         one-hot grant
//  WIDTH      out  WID_W        configured width to par_reg
//  op         out  REG_W        assembled register image
//  op_valid   out  1            1-cycle pulse, op complete
//  busy       out  1            high in any state except IDLE
//  err        out  1            1-cycle pulse, zero-width request rejected
//  abort      out  1            1-cycle pulse, granted req dropped during LOAD
// BEHAVIOUR
//  Reset (reset==0 at edge): gnt, s_ready, WIDTH, op, op_valid, busy, err, abort = 0;
//   state IDLE; rr pointer = 0. Reset mid-operation discards the transfer immediately.
//  States: IDLE -> CFG -> LOAD -> DONE -> IDLE; all outputs registered.
//  IDLE: pick first asserted req searching from rr pointer upward, wrapping.
//   width==0 -> err pulse next cycle, stay IDLE, rr pointer advances past it.
//   width>REG_W -> clamped to REG_W. Else latch g, width; go CFG.
//  CFG (1 cycle): gnt[g]=1, WIDTH=width, op=0, beat count=0, busy=1.
//  LOAD: s_ready[g]=1; on s_valid[g]&s_ready[g] write op[cnt*DATA_W +: DATA_W],
//   cnt++. Beats = ceil(width/DATA_W). Bits at index >= width forced to 0.
//   Last beat accepted -> DONE. s_valid low = stall, no timeout.
//   req[g] low in LOAD -> abort pulse, op=0, gnt=0, IDLE; rr pointer = g+1.
//   Other requesters' req/s_valid ignored while busy.
//  DONE (1 cycle): op_valid=1, gnt=0, s_ready=0, rr pointer = (g+1) mod NREQ.
//   op and WIDTH hold until next CFG.
//  Latency: req in IDLE at edge n -> gnt at n+1, s_ready at n+2; op_valid the
//   cycle after the last accepted beat. Minimum turnaround 4 cycles per request.
// STRUCTURE
//  par_reg_pkg: state encoding (IDLE/CFG/LOAD/DONE), REG_W, DATA_W, WID_W,
//   MAX_BEATS=REG_W/DATA_W, beat-count width.
//  Sub-module rr_arbiter: NREQ req + pointer -> one-hot pick + index,
//   combinational; pointer register stays in par_reg_ctrl.
//  Top holds FSM, beat counter, width latch, op image and width mask.
// TESTING
//  1 reset=0 for 3 cycles mid-LOAD -> all outputs 0, busy=0, next req granted as req0 first.
//  2 req0, width=4, beat 0xFFFFFFFF -> WIDTH=4, op=0x...000F, op_valid 1 cycle, gnt0 dropped.
//  3 req1, width=40, beats 0xAAAAAAAA,0xFFFFFFFF -> op[31:0]=AAAAAAAA, op[39:32]=FF, op[511:40]=0.
//  4 req0&req1 together, width=8 -> gnt0 first then gnt1; repeat -> gnt0 again (rr fair).
//  5 width=0 -> err pulse, no gnt; width=600 -> WIDTH=512, exactly 16 beats accepted.
//  6 req0 dropped after 1 of 2 beats -> abort pulse, op=0, busy=0; s_valid gaps stall only.

Source files
------------

// File: rtl/par_reg_pkg.sv
// Shared constants for the par_reg sequencer: geometry, beat counter sizing, FSM encoding.
package par_reg_pkg;
  localparam int REG_W     = 512;
  localparam int DATA_W    = 32;
  localparam int WID_W     = 10;
  localparam int MAX_BEATS = REG_W / DATA_W;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CFG  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  int j;

  always_comb begin
    idx = '0;
    j   = 0;
    any = |req;
    // Walk offsets from far to near so the closest hit to ptr is the last writer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) idx = IDX_W'(j);
    end
    pick = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/par_reg_ctrl.sv
// Arbitrates NREQ requesters onto par_reg: configures WIDTH, assembles beats into op, pulses op_valid.
module par_reg_ctrl import par_reg_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int DATA_W = par_reg_pkg::DATA_W,
  parameter int REG_W  = par_reg_pkg::REG_W,
  parameter int WID_W  = par_reg_pkg::WID_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WID_W-1:0]    req_width,
  input  logic [NREQ*DATA_W-1:0]   s_data,
  input  logic [NREQ-1:0]          s_valid,
  output logic [NREQ-1:0]          s_ready,
  output logic [NREQ-1:0]          gnt,
  output logic [WID_W-1:0]         WIDTH,
  output logic [REG_W-1:0]         op,
  output logic                     op_valid,
  output logic                     busy,
  output logic                     err,
  output logic                     abort
);
  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BCNT_W = $clog2(REG_W / DATA_W + 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr, g_q, pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic              pick_any;
  logic [BCNT_W-1:0] cnt, beats_q, w_beats;
  logic [WID_W-1:0]  w_req, w_clamp;
  logic [REG_W-1:0]  mask;
  logic [DATA_W-1:0] beat;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req  (req),
    .ptr  (rr_ptr),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign w_req   = req_width[pick_idx*WID_W +: WID_W];
  assign w_clamp = (w_req > WID_W'(REG_W)) ? WID_W'(REG_W) : w_req;
  assign w_beats = BCNT_W'((32'(w_clamp) + DATA_W - 1) / DATA_W);

  // Bits at or above the configured width never reach op.
  always_comb begin
    mask = '0;
    for (int i = 0; i < REG_W; i++) mask[i] = (i < int'(WIDTH));
  end

  assign beat = s_data[g_q*DATA_W +: DATA_W] & mask[cnt*DATA_W +: DATA_W];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      g_q      <= '0;
      cnt      <= '0;
      beats_q  <= '0;
      gnt      <= '0;
      s_ready  <= '0;
      WIDTH    <= '0;
      op       <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      abort    <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      err      <= 1'b0;
      abort    <= 1'b0;
      case (state)
        ST_IDLE: if (pick_any) begin
          if (w_req == '0) begin
            err    <= 1'b1;
            rr_ptr <= nxt(pick_idx);
          end else begin
            g_q     <= pick_idx;
            gnt     <= pick_oh;
            WIDTH   <= w_clamp;
            beats_q <= w_beats;
            op      <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_CFG;
          end
        end
        ST_CFG: begin
          s_ready <= gnt;
          state   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!req[g_q]) begin
            abort   <= 1'b1;
            op      <= '0;
            gnt     <= '0;
            s_ready <= '0;
            busy    <= 1'b0;
            rr_ptr  <= nxt(g_q);
            state   <= ST_IDLE;
          end else if (s_valid[g_q]) begin
            op[cnt*DATA_W +: DATA_W] <= beat;
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == beats_q) begin
              op_valid <= 1'b1;
              gnt      <= '0;
              s_ready  <= '0;
              rr_ptr   <= nxt(g_q);
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_par_reg_ctrl.sv
// Scoreboard bench for par_reg_ctrl: expected images queued at grant, checked on op_valid.
module tb_par_reg_ctrl;
  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int RW   = 512;
  localparam int WW   = 10;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req, s_valid, s_ready, gnt;
  logic [NREQ*WW-1:0]   req_width;
  logic [NREQ*DW-1:0]   s_data;
  logic [WW-1:0]        WIDTH;
  logic [RW-1:0]        op;
  logic                 op_valid, busy, err, abort;

  par_reg_ctrl #(.NREQ(NREQ), .DATA_W(DW), .REG_W(RW), .WID_W(WW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_width(req_width),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .gnt(gnt),
    .WIDTH(WIDTH), .op(op), .op_valid(op_valid), .busy(busy), .err(err), .abort(abort)
  );

  always #5 clock = ~clock;

  typedef struct { logic [RW-1:0] img; logic [WW-1:0] w; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] beats[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int w);
    exp_t e;
    int   wc;
    wc    = (w > RW) ? RW : w;
    e.img = '0;
    for (int k = 0; k < beats.size(); k++) e.img[k*DW +: DW] = beats[k];
    for (int i = 0; i < RW; i++) if (i >= wc) e.img[i] = 1'b0;
    e.w = WW'(wc);
    return e;
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b1 && op_valid === 1'b1) begin
      exp_t e;
      chk("sb_nonempty", RW'(exp_q.size() != 0), RW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("op", op, e.img);
        chk("width", RW'(WIDTH), RW'(e.w));
      end
      chk("gnt_done", RW'(gnt), RW'(0));
      chk("rdy_done", RW'(s_ready), RW'(0));
    end
  end

  task automatic start_req(input int r, input int w);
    req[r] = 1'b1;
    req_width[r*WW +: WW] = WW'(w);
  endtask

  task automatic wait_gnt(input int r);
    int t = 0;
    while (gnt[r] !== 1'b1 && t < 40) begin @(negedge clock); t++; end
    chk("gnt", RW'(gnt), RW'(1) << r);
  endtask

  task automatic send_beat(input int r, input logic [DW-1:0] d);
    int t = 0;
    s_valid[r] = 1'b1;
    s_data[r*DW +: DW] = d;
    while (s_ready[r] !== 1'b1 && t < 40) begin @(negedge clock); t++; end
    @(negedge clock);
    s_valid[r] = 1'b0;
  endtask

  task automatic serve(input int r, input int w, input int gap);
    exp_t e;
    int   nb;
    e  = model(w);
    nb = (((w > RW) ? RW : w) + DW - 1) / DW;
    wait_gnt(r);
    chk("cfg_width", RW'(WIDTH), RW'(e.w));
    chk("cfg_op", op, '0);
    chk("cfg_rdy", RW'(s_ready), RW'(0));
    chk("cfg_busy", RW'(busy), RW'(1));
    exp_q.push_back(e);
    for (int k = 0; k < nb; k++) begin
      send_beat(r, beats[k]);
      if (k < nb - 1) repeat (gap) @(negedge clock);
    end
    chk("opv", RW'(op_valid), RW'(1));
    req[r] = 1'b0;
    @(negedge clock);
    chk("opv_pulse", RW'(op_valid), RW'(0));
    chk("busy_idle", RW'(busy), RW'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = '0; s_valid = '0; s_data = '0; req_width = '0;
    repeat (3) @(negedge clock);
    chk("rst_out", RW'({gnt, s_ready, WIDTH, op_valid, busy, err, abort}), RW'(0));
    chk("rst_op", op, '0);
    reset = 1'b1;

    // width 4, all-ones beat: only the low nibble survives
    beats = '{32'hFFFF_FFFF};
    start_req(0, 4);
    @(negedge clock);
    chk("gnt_lat", RW'(gnt), RW'(1));
    serve(0, 4, 0);

    // two beats with stalls between them, partial second beat
    beats = '{32'hAAAA_AAAA, 32'hFFFF_FFFF};
    start_req(1, 40);
    serve(1, 40, 2);

    // simultaneous requests alternate fairly
    beats = '{32'h1234_5678};
    repeat (2) begin
      start_req(0, 8);
      start_req(1, 8);
      serve(0, 8, 0);
      serve(1, 8, 0);
    end

    // zero width rejected
    start_req(0, 0);
    @(negedge clock);
    chk("err", RW'(err), RW'(1));
    chk("err_gnt", RW'(gnt), RW'(0));
    req[0] = 1'b0;
    @(negedge clock);
    chk("err_pulse", RW'(err), RW'(0));

    // oversize width clamps to a full 16-beat image
    beats.delete();
    for (int k = 0; k < RW / DW; k++) beats.push_back($urandom());
    start_req(1, 600);
    serve(1, 600, 0);

    // drop req after one of two beats
    beats = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    start_req(0, 64);
    wait_gnt(0);
    send_beat(0, beats[0]);
    repeat (2) begin
      @(negedge clock);
      chk("stall_busy", RW'(busy), RW'(1));
      chk("stall_opv", RW'(op_valid), RW'(0));
    end
    req[0] = 1'b0;
    @(negedge clock);
    chk("abort", RW'(abort), RW'(1));
    chk("abort_op", op, '0);
    chk("abort_idle", RW'({busy, gnt, s_ready}), RW'(0));
    @(negedge clock);
    chk("abort_pulse", RW'(abort), RW'(0));

    // reset in the middle of a load; pointer must restart at requester 0
    beats = '{32'h1111_1111, 32'h2222_2222};
    start_req(1, 64);
    wait_gnt(1);
    send_beat(1, beats[0]);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("midrst_out", RW'({gnt, s_ready, WIDTH, op_valid, busy, err, abort}), RW'(0));
    chk("midrst_op", op, '0);
    req = '0;
    reset = 1'b1;
    beats = '{32'h0000_00A5};
    start_req(0, 8);
    start_req(1, 8);
    @(negedge clock);
    chk("rr_after_rst", RW'(gnt), RW'(1));
    serve(0, 8, 0);
    serve(1, 8, 0);

    @(negedge clock);
    chk("sb_drain", RW'(exp_q.size()), RW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
